// File: rtl/mem_port_sched.sv
// mem_port_sched: shares one byte-wide RAM/IO port between instruction fetch
// (32-bit reads) and load/store (1/2/4-byte reads/writes). Requests are split
// into little-endian byte beats; read bytes are assembled and each requester
// gets a one-cycle done pulse.
// Optional build macro MEM_SCHED_FAIR_EN: an age counter hands the port to a
// waiting fetch after two consecutive load/store grants.
module mem_port_sched #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              io_buffer_full,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  input  logic              if_flush_in,
  output logic              if_done_out,
  output logic [31:0]       if_data_out,
  input  logic              ls_req_in,
  input  logic              ls_we_in,
  input  logic [1:0]        ls_size_in,
  input  logic [ADDR_W-1:0] ls_addr_in,
  input  logic [31:0]       ls_wdata_in,
  output logic              ls_done_out,
  output logic [31:0]       ls_rdata_out,
  output logic              busy_out,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e            state_q, state_d;
  logic              own_ls_q, own_ls_d;     // 1: load/store owns the port, 0: fetch
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        len_q, len_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        iss_q, iss_d;           // beats issued so far
  logic [1:0]        cap_q, cap_d;           // read bytes captured so far
  // [0]: a beat was issued on the last edge; [1]: two edges ago, so mem_din holds it now
  logic [1:0]        vld_pipe_q, vld_pipe_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       ls_rdata_q, ls_rdata_d;
  logic              if_done_q, if_done_d;
  logic              ls_done_q, ls_done_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;

  logic              grant_if, grant_ls;
  logic [2:0]        ls_len;
  logic [31:0]       cap_word;

  function automatic logic is_io(input logic [ADDR_W-1:0] a);
    return a[17:16] == IO_SEL;
  endfunction

  // size 3 is handled as a word
  always_comb begin
    unique case (ls_size_in)
      2'd0:    ls_len = 3'd1;
      2'd1:    ls_len = 3'd2;
      default: ls_len = 3'd4;
    endcase
  end

  // a flush in the same cycle as a fetch request blocks the fetch grant
`ifdef MEM_SCHED_FAIR_EN
  logic [1:0] age_q, age_d;

  assign grant_if = if_req_in && !if_flush_in && (!ls_req_in || age_q == 2'd2);
  assign grant_ls = ls_req_in && !grant_if;

  // count load/store grants that overtook a waiting fetch; clear when fetch wins
  always_comb begin
    age_d = age_q;
    if (rdy_in && state_q == IDLE) begin
      if (grant_if)                                  age_d = 2'd0;
      else if (grant_ls && if_req_in && age_q != 2'd2) age_d = age_q + 2'd1;
    end
  end

  // age counter register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) age_q <= 2'd0;
    else         age_q <= age_d;
  end
`else
  assign grant_if = if_req_in && !if_flush_in && !ls_req_in;
  assign grant_ls = ls_req_in;
`endif

  // next-state, beat sequencing and read assembly; everything holds while rdy_in is low
  always_comb begin
    state_d    = state_q;
    own_ls_d   = own_ls_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    iss_d      = iss_q;
    cap_d      = cap_q;
    vld_pipe_d = vld_pipe_q;
    asm_d      = asm_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    if_done_d  = if_done_q;
    ls_done_d  = ls_done_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    cap_word   = asm_q;
    cap_word[{cap_q, 3'b000} +: 8] = mem_din;

    if (rdy_in) begin
      if_done_d  = 1'b0;
      ls_done_d  = 1'b0;
      vld_pipe_d = {vld_pipe_q[0], 1'b0};
      unique case (state_q)
        IDLE: begin
          if (grant_ls || grant_if) begin
            own_ls_d = grant_ls;
            addr_d   = grant_ls ? ls_addr_in : if_addr_in;
            len_d    = grant_ls ? ls_len : 3'd4;
            wdata_d  = ls_wdata_in;
            asm_d    = '0;
            cap_d    = '0;
            mem_a_d  = grant_ls ? ls_addr_in : if_addr_in;
            if (grant_ls && ls_we_in) begin
              state_d = WRITE;
              if (is_io(ls_addr_in) && io_buffer_full) begin
                iss_d    = 3'd0;
                mem_wr_d = 1'b0;
              end else begin
                iss_d      = 3'd1;
                mem_wr_d   = 1'b1;
                mem_dout_d = ls_wdata_in[7:0];
              end
            end else begin
              state_d       = READ;
              iss_d         = 3'd1;
              vld_pipe_d[0] = 1'b1;
            end
          end
        end
        READ: begin
          if (!own_ls_q && if_flush_in) begin
            // abandon the fetch; bytes still in flight are dropped, mem_a keeps its value
            state_d    = IDLE;
            vld_pipe_d = '0;
            iss_d      = 3'd0;
          end else begin
            if (iss_q < len_q) begin
              mem_a_d       = addr_q + ADDR_W'(iss_q);
              iss_d         = iss_q + 3'd1;
              vld_pipe_d[0] = 1'b1;
            end
            if (vld_pipe_q[1]) begin
              asm_d = cap_word;
              cap_d = cap_q + 2'd1;
              if (3'(cap_q) + 3'd1 == len_q) begin
                state_d = DONE;
                if (own_ls_q) begin
                  ls_rdata_d = cap_word;
                  ls_done_d  = 1'b1;
                end else begin
                  if_data_d = cap_word;
                  if_done_d = 1'b1;
                end
              end
            end
          end
        end
        WRITE: begin
          if (iss_q < len_q) begin
            if (is_io(addr_q) && io_buffer_full) begin
              mem_wr_d = 1'b0;
            end else begin
              mem_a_d    = addr_q + ADDR_W'(iss_q);
              mem_dout_d = wdata_q[{iss_q[1:0], 3'b000} +: 8];
              mem_wr_d   = 1'b1;
              iss_d      = iss_q + 3'd1;
            end
          end else begin
            mem_wr_d  = 1'b0;
            state_d   = DONE;
            ls_done_d = 1'b1;
          end
        end
        DONE: begin
          state_d    = IDLE;
          iss_d      = 3'd0;
          vld_pipe_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      own_ls_q   <= 1'b0;
      addr_q     <= '0;
      len_q      <= 3'd0;
      wdata_q    <= '0;
      iss_q      <= 3'd0;
      cap_q      <= 2'd0;
      vld_pipe_q <= '0;
      asm_q      <= '0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_ls_q   <= own_ls_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      iss_q      <= iss_d;
      cap_q      <= cap_d;
      vld_pipe_q <= vld_pipe_d;
      asm_q      <= asm_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  // a flush landing in the fetch's done cycle cancels the pulse;
  // a frozen pipeline must never write, so mem_wr drops with rdy_in
  assign if_done_out  = if_done_q && !if_flush_in;
  assign ls_done_out  = ls_done_q;
  assign if_data_out  = if_data_q;
  assign ls_rdata_out = ls_rdata_q;
  assign busy_out     = state_q != IDLE;
  assign mem_a        = mem_a_q;
  assign mem_dout     = mem_dout_q;
  assign mem_wr       = mem_wr_q && rdy_in;

endmodule
